fg_prog_sequencer: RTL and testbench

//  Sequences floating-gate programming of one analog island (TA2 cell column plus drain/gate decoders).

---
 rtl/fg_prog_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one analog island.
// Runs setup, pulse train and teardown, then returns the island to RUN.
module fg_prog_sequencer #(
    parameter int DRAIN_BITS = 5,
    parameter int GATE_BITS  = 2,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 16,
    parameter int PULSE_CYC  = 100,
    parameter int GAP_CYC    = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DRAIN_BITS-1:0] i_cmd_drain,
    input  logic [GATE_BITS-1:0]  i_cmd_gate,
    input  logic [CNT_W-1:0]      i_cmd_pulses,
    input  logic                  i_abort,
    output logic                  o_prog,
    output logic                  o_run,
    output logic                  o_vgsel,
    output logic [GATE_BITS-1:0]  o_gate_b,
    output logic                  o_gate_enable,
    output logic [DRAIN_BITS-1:0] o_drain_b,
    output logic                  o_drain_enable,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic [CNT_W-1:0]      o_pulses_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_GATE_ON,
        S_PULSE,
        S_GAP,
        S_GATE_OFF,
        S_EXIT
    } state_t;

    localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] L_PULSE  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(GAP_CYC - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_bbm;
    logic [CNT_W-1:0]      r_npulses;
    logic [CNT_W-1:0]      r_pulses_done;
    logic                  r_ready;
    logic                  r_prog;
    logic                  r_run;
    logic                  r_vgsel;
    logic [GATE_BITS-1:0]  r_gate_b;
    logic                  r_gate_en;
    logic [DRAIN_BITS-1:0] r_drain_b;
    logic                  r_drain_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;

    logic                  w_expired;
    logic                  w_abort;
    logic [CNT_W-1:0]      w_pulses_next;

    assign w_expired     = (r_cnt == '0);
    assign w_pulses_next = r_pulses_done + 1'b1;
    assign w_abort       = i_abort &&
                           (r_state == S_ENTER || r_state == S_GATE_ON ||
                            r_state == S_PULSE || r_state == S_GAP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bbm         <= 1'b0;
            r_npulses     <= '0;
            r_pulses_done <= '0;
            r_ready       <= 1'b1;
            r_prog        <= 1'b0;
            r_run         <= 1'b1;
            r_vgsel       <= 1'b0;
            r_gate_b      <= '0;
            r_gate_en     <= 1'b0;
            r_drain_b     <= '0;
            r_drain_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_cmd_valid) begin
                    r_drain_b     <= i_cmd_drain;
                    r_gate_b      <= i_cmd_gate;
                    r_npulses     <= i_cmd_pulses;
                    r_pulses_done <= '0;
                    r_aborted     <= 1'b0;
                    r_run         <= 1'b0;
                    r_ready       <= 1'b0;
                    r_busy        <= 1'b1;
                    r_bbm         <= 1'b1;
                    r_cnt         <= L_SETTLE;
                    r_state       <= S_ENTER;
                end
            end else if (w_abort) begin
                // abort wins over a pulse expiring on the same edge
                r_state    <= S_GATE_OFF;
                r_drain_en <= 1'b0;
                r_gate_en  <= 1'b0;
                r_aborted  <= 1'b1;
                r_bbm      <= 1'b0;
                r_cnt      <= L_SETTLE;
            end else begin
                unique case (r_state)
                    S_ENTER: begin
                        if (r_bbm) begin
                            r_bbm   <= 1'b0;
                            r_prog  <= 1'b1;
                            r_vgsel <= 1'b1;
                        end else if (w_expired) begin
                            r_state   <= S_GATE_ON;
                            r_gate_en <= 1'b1;
                            r_cnt     <= L_SETTLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_GATE_ON: begin
                        if (!w_expired) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (r_npulses == '0) begin
                            r_state   <= S_GATE_OFF;
                            r_gate_en <= 1'b0;
                            r_cnt     <= L_SETTLE;
                        end else begin
                            r_state    <= S_PULSE;
                            r_drain_en <= 1'b1;
                            r_cnt      <= L_PULSE;
                        end
                    end
                    S_PULSE: begin
                        if (!w_expired) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_drain_en <= 1'b0;
                            if (r_pulses_done != r_npulses)
                                r_pulses_done <= w_pulses_next;
                            if (w_pulses_next == r_npulses) begin
                                r_state   <= S_GATE_OFF;
                                r_gate_en <= 1'b0;
                                r_cnt     <= L_SETTLE;
                            end else begin
                                r_state <= S_GAP;
                                r_cnt   <= L_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_expired) begin
                            r_state    <= S_PULSE;
                            r_drain_en <= 1'b1;
                            r_cnt      <= L_PULSE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_GATE_OFF: begin
                        if (w_expired) begin
                            r_state <= S_EXIT;
                            r_prog  <= 1'b0;
                            r_vgsel <= 1'b0;
                            r_cnt   <= L_SETTLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_EXIT: begin
                        if (w_expired) begin
                            r_state   <= S_IDLE;
                            r_run     <= 1'b1;
                            r_gate_b  <= '0;
                            r_drain_b <= '0;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_IDLE: begin
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready    = r_ready;
    assign o_prog         = r_prog;
    assign o_run          = r_run;
    assign o_vgsel        = r_vgsel;
    assign o_gate_b       = r_gate_b;
    assign o_gate_enable  = r_gate_en;
    assign o_drain_b      = r_drain_b;
    assign o_drain_enable = r_drain_en;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_aborted      = r_aborted;
    assign o_pulses_done  = r_pulses_done;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: closed-form timeline model of each command,
// compared against every output on every cycle, plus a rail invariant monitor.
module tb_fg_prog_sequencer;

    localparam int S = 16;
    localparam int P = 100;
    localparam int G = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_drain;
    logic [1:0] cmd_gate;
    logic [7:0] cmd_pulses;
    logic       abort;
    logic       prog;
    logic       run;
    logic       vgsel;
    logic [1:0] gate_b;
    logic       gate_enable;
    logic [4:0] drain_b;
    logic       drain_enable;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] pulses_done;

    int n_pass  = 0;
    int n_total = 0;
    bit inv_on  = 1'b0;

    fg_prog_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_drain    (cmd_drain),
        .i_cmd_gate     (cmd_gate),
        .i_cmd_pulses   (cmd_pulses),
        .i_abort        (abort),
        .o_prog         (prog),
        .o_run          (run),
        .o_vgsel        (vgsel),
        .o_gate_b       (gate_b),
        .o_gate_enable  (gate_enable),
        .o_drain_b      (drain_b),
        .o_drain_enable (drain_enable),
        .o_busy         (busy),
        .o_done         (done),
        .o_aborted      (aborted),
        .o_pulses_done  (pulses_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inv_on && !rst) begin
            n_total++;
            assert (!(prog && run) &&
                    (!drain_enable || (gate_enable && prog)) &&
                    (!gate_enable || prog))
                n_pass++;
            else
                $error("FAIL invariant prog=%b run=%b ge=%b de=%b",
                       prog, run, gate_enable, drain_enable);
        end
    end

    function automatic logic [23:0] obs_vec();
        return {prog, run, vgsel, gate_enable, drain_enable, busy, done,
                aborted, cmd_ready, gate_b, drain_b, pulses_done};
    endfunction

    localparam logic [23:0] RESET_VEC = {9'b010000001, 2'd0, 5'd0, 8'd0};

    task automatic chk(input string tag, input int k,
                       input logic [23:0] o, input logic [23:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    endtask

    // Expected outputs k edges after the accept edge; T is the teardown start.
    function automatic logic [23:0] model(int k, int n, int T, bit ab,
                                          logic [4:0] d, logic [1:0] g);
        bit e_busy, e_done, e_prog, e_run, e_ge, e_de, e_ab;
        int pd, s, e;
        e_busy = (k < T + 2 * S);
        e_done = (k == T + 2 * S);
        e_prog = (k >= 1) && (k < T + S) && (T > 1);
        e_run  = (k >= T + 2 * S);
        e_ge   = (k >= 1 + S) && (k < T);
        e_de   = 1'b0;
        pd     = 0;
        for (int i = 0; i < n; i++) begin
            s = 1 + 2 * S + i * (P + G);
            e = s + P;
            if (k >= s && k < e && k < T) e_de = 1'b1;
            if (e <= k && (e < T || (e == T && !ab))) pd++;
        end
        e_ab = ab && (k >= T);
        return {e_prog, e_run, e_prog, e_ge, e_de, e_busy, e_done, e_ab,
                !e_busy, e_busy ? g : 2'd0, e_busy ? d : 5'd0, pd[7:0]};
    endfunction

    // ka: edge (after accept) at which abort is sampled, 0 = none.
    // ka2off: extra abort pulse this many edges into teardown, 0 = none.
    task automatic run_cmd(input string tag, input logic [4:0] d,
                           input logic [1:0] g, input int n, input int ka,
                           input int ka2off, input bit hold);
        int  t0, t, ka2;
        bit  ab;
        t0  = (n == 0) ? 1 + 2 * S : 1 + 2 * S + n * P + (n - 1) * G;
        ab  = (ka >= 1) && (ka <= t0);
        t   = ab ? ka : t0;
        ka2 = (ka2off > 0) ? t + ka2off : -1;
        cmd_drain  = d;
        cmd_gate   = g;
        cmd_pulses = n[7:0];
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k <= t + 2 * S; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 0 && !hold) begin
                cmd_valid  = 1'b0;
                cmd_drain  = 5'($urandom);
                cmd_gate   = 2'($urandom);
                cmd_pulses = 8'($urandom);
            end
            chk(tag, k, obs_vec(), model(k, n, t, ab, d, g));
            abort = (k + 1 == ka) || (k + 1 == ka2);
        end
        abort = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_drain  = '0;
        cmd_gate   = '0;
        cmd_pulses = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, obs_vec(), RESET_VEC);
        rst    = 1'b0;
        inv_on = 1'b1;
        @(posedge clk);
        #1;
        chk("idle", 0, obs_vec(), RESET_VEC);

        run_cmd("three_pulses", 5'd19, 2'd2, 3, 0, 0, 1'b0);
        chk("three_pd", 0, {16'd0, pulses_done}, 24'd3);
        chk("three_ab", 0, {23'd0, aborted}, 24'd0);

        run_cmd("zero_pulses", 5'd7, 2'd1, 0, 0, 0, 1'b0);

        run_cmd("abort_p2", 5'd3, 2'd3, 5, 1 + 2 * S + (P + G) + 50, 5, 1'b0);
        chk("abort_pd", 0, {16'd0, pulses_done}, 24'd1);
        chk("abort_ab", 0, {23'd0, aborted}, 24'd1);

        run_cmd("hold_valid_a", 5'd10, 2'd0, 1, 0, 0, 1'b1);
        run_cmd("hold_valid_b", 5'd21, 2'd1, 2, 0, 0, 1'b0);

        cmd_drain  = 5'd12;
        cmd_gate   = 2'd2;
        cmd_pulses = 8'd4;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2 * S + 20) @(posedge clk);
        #1;
        chk("rst_in_pulse", 0, {23'd0, drain_enable}, 24'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", 0, obs_vec(), RESET_VEC);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_after", 0, obs_vec(), RESET_VEC);

        for (int r = 0; r < 12; r++) begin
            int n, t0, ka;
            n  = $urandom_range(0, 4);
            t0 = (n == 0) ? 1 + 2 * S : 1 + 2 * S + n * P + (n - 1) * G;
            ka = ($urandom_range(0, 1) == 1) ? $urandom_range(1, t0 + 3) : 0;
            run_cmd("random", 5'($urandom), 2'($urandom), n, ka,
                    $urandom_range(0, 2 * S - 1), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
